// File: rtl/mux_scan_ctrl_if.sv
// Output sample stream of mux_scan_ctrl.
// The stream carries a captured mux word together with its channel number.
// Transfers use a valid/ready handshake.
interface mux_scan_ctrl_if #(
  parameter int WIDTH = 6
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_chan;

  modport master (
    output out_valid,
    output out_data,
    output out_chan,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_chan,
    output out_ready
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives the select of an attached 8:1 mux and walks the
// channels enabled in a latched mask, in ascending order. For each channel it
// allows one settle cycle, captures the mux output, and offers it with its
// channel number on a valid/ready stream. A start with an empty mask only
// produces a done pulse.
// Optional feature macro MUX_SCAN_CONTINUOUS_EN: a start presented on the final
// handshake of a scan chains straight into the next scan without passing
// through IDLE.
module mux_scan_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       chan_mask,
  output logic [2:0]       sel,
  input  logic [WIDTH-1:0] mux_y,
  mux_scan_ctrl_if.master  out_if,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       mask_q, mask_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       chan_q, chan_d;
  logic             done_q, done_d;

  logic [7:0]       above_mask;
  logic             has_next;
  logic [2:0]       next_chan;

  // Index of the lowest set bit; returns 0 for an empty vector.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Search only the latched channels strictly above the current select.
  // There is no wrap back to lower channels.
  always_comb begin
    above_mask = mask_q & ~((8'h02 << sel_q) - 8'h01);
    has_next   = |above_mask;
    next_chan  = lowest_set(above_mask);
  end

  // Next-state logic and next values for all registered outputs.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (chan_mask != 8'h00) begin
            mask_d  = chan_mask;
            sel_d   = lowest_set(chan_mask);
            state_d = SETTLE;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SETTLE: begin
        data_d  = mux_y;
        chan_d  = sel_q;
        valid_d = 1'b1;
        state_d = HOLD;
      end

      HOLD: begin
        if (valid_q && out_if.out_ready) begin
          valid_d = 1'b0;
          if (has_next) begin
            sel_d   = next_chan;
            state_d = SETTLE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef MUX_SCAN_CONTINUOUS_EN
            if (start && (chan_mask != 8'h00)) begin
              mask_d  = chan_mask;
              sel_d   = lowest_set(chan_mask);
              state_d = SETTLE;
            end
`endif
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset returns the controller to IDLE at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers. Reset discards any pending sample without a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 3'd0;
      mask_q  <= 8'h00;
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      done_q  <= done_d;
    end
  end

  assign sel              = sel_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_chan  = chan_q;

endmodule
